// File: rtl/acc_pkg.sv
// Shared types and default widths for the commanded accumulator
// (run controller and ripple-carry core).
package acc_pkg;

  localparam int ACC_WIDTH = 16;
  localparam int ADD_WIDTH = 1;
  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_ripple_core.sv
// Accumulator register with a ripple-carry adder.
// carry_out is the carry of the add that en would commit on the next edge.
module acc_ripple_core #(
  parameter int ACC_WIDTH = acc_pkg::ACC_WIDTH,
  parameter int ADD_WIDTH = acc_pkg::ADD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [ADD_WIDTH-1:0] add_value,
  output logic [ACC_WIDTH-1:0] data,
  output logic                 carry_out
);
  import acc_pkg::*;

  function automatic logic [ACC_WIDTH:0] ripple_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH-1:0] s;
    logic                 c;
    c = 1'b0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic [ACC_WIDTH-1:0] data_q, data_d;
  logic [ACC_WIDTH:0]   sum_s;

  assign sum_s     = ripple_add(data_q, ACC_WIDTH'(add_value));
  assign carry_out = sum_s[ACC_WIDTH];
  assign data      = data_q;

  // Next accumulator value: clear has priority over add.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = sum_s[ACC_WIDTH-1:0];
    end else begin
      data_d = data_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/acc_run_ctrl.sv
// Run controller: accepts one {addend, steps, clear} command, drives the
// accumulator core for that many cycles and holds the result until taken.
module acc_run_ctrl #(
  parameter int ACC_WIDTH = acc_pkg::ACC_WIDTH,
  parameter int ADD_WIDTH = acc_pkg::ADD_WIDTH,
  parameter int CNT_WIDTH = acc_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADD_WIDTH-1:0] cmd_add,
  input  logic [CNT_WIDTH-1:0] cmd_steps,
  input  logic                 cmd_clear,
  input  logic                 abort,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_data,
  output logic                 res_ovf,
  output logic                 res_aborted,
  output logic                 busy,
  output logic                 acc_msb
);
  import acc_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADD_WIDTH-1:0] addend_q, addend_d;
  logic                 ovf_q, ovf_d;
  logic                 aborted_q, aborted_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
  logic                 res_valid_q, res_valid_d;
  logic                 core_en_s, core_clr_s, core_carry_s;
  logic [ACC_WIDTH-1:0] core_data_s;

  acc_ripple_core #(
    .ACC_WIDTH (ACC_WIDTH),
    .ADD_WIDTH (ADD_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (core_en_s),
    .clr       (core_clr_s),
    .add_value (addend_q),
    .data      (core_data_s),
    .carry_out (core_carry_s)
  );

  // Next-state, counter, flag and core-control decode; abort beats the final step.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addend_d    = addend_q;
    ovf_d       = ovf_q;
    aborted_d   = aborted_q;
    core_en_s   = 1'b0;
    core_clr_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addend_d   = cmd_add;
          cnt_d      = cmd_steps;
          ovf_d      = 1'b0;
          aborted_d  = 1'b0;
          core_clr_s = cmd_clear;
          if (cmd_steps != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          core_en_s = 1'b1;
          ovf_d     = ovf_q | core_carry_s;
          cnt_d     = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_RUN);
    res_valid_d = (state_d == S_DONE);
  end

  // FSM state, run bookkeeping and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addend_q    <= '0;
      ovf_q       <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addend_q    <= addend_d;
      ovf_q       <= ovf_d;
      aborted_q   <= aborted_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = core_data_s;
  assign res_ovf     = ovf_q;
  assign res_aborted = aborted_q;
  assign acc_msb     = core_data_s[ACC_WIDTH-1];

endmodule

// File: tb/tb_acc_run_ctrl.sv
// Self-checking bench for acc_run_ctrl: command table plus hand-written
// sequences for overflow, zero-step runs, abort and reset corner cases.
module tb_acc_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_add = 1'b0;
  logic [7:0]  cmd_steps = 8'd0;
  logic        cmd_clear = 1'b0;
  logic        abort = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_ovf;
  logic        res_aborted;
  logic        busy;
  logic        acc_msb;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
    logic        ab;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        add;
    int          steps;
    logic        clr;
    int          abort_at;
    logic [15:0] data;
    logic        ovf;
    logic        ab;
    int          hold;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  acc_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_add     (cmd_add),
    .cmd_steps   (cmd_steps),
    .cmd_clear   (cmd_clear),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_ovf     (res_ovf),
    .res_aborted (res_aborted),
    .busy        (busy),
    .acc_msb     (acc_msb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, " res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " busy"},      {31'd0, busy},      32'd0);
    chk({tag, " res_data"},  {16'd0, res_data},  32'd0);
    chk({tag, " acc_msb"},   {31'd0, acc_msb},   32'd0);
  endtask

  // One full command: offer, run (optional abort), compare result, hold, take.
  task automatic do_cmd(input logic add, input int steps, input logic clr, input int abort_at,
                        input logic [15:0] e_data, input logic e_ovf, input logic e_ab,
                        input int hold);
    int   cycles;
    int   exp_lat;
    exp_t e;
    sb_q.push_back({e_data, e_ovf, e_ab});
    if (steps == 0) exp_lat = 1;
    else if (abort_at > 0 && abort_at <= steps) exp_lat = abort_at + 1;
    else exp_lat = steps + 1;
    chk("cmd_ready before accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_add   = add;
    cmd_steps = steps[7:0];
    cmd_clear = clr;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_add   = ~add;
    cmd_steps = 8'($urandom);
    cmd_clear = ~clr;
    cycles = 1;
    while (!res_valid && cycles < 400) begin
      abort = (cycles == abort_at);
      @(negedge clk);
      cycles++;
    end
    abort = 1'b0;
    chk("latency", cycles, exp_lat);
    e = sb_q.pop_front();
    chk("res_data", {16'd0, res_data}, {16'd0, e.data});
    chk("res_ovf", {31'd0, res_ovf}, {31'd0, e.ovf});
    chk("res_aborted", {31'd0, res_aborted}, {31'd0, e.ab});
    chk("acc_msb", {31'd0, acc_msb}, {31'd0, e.data[15]});
    chk("cmd_ready while done", {31'd0, cmd_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("res_valid held", {31'd0, res_valid}, 32'd1);
      chk("res_data held", {16'd0, res_data}, {16'd0, e.data});
      chk("cmd_ready held low", {31'd0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid after take", {31'd0, res_valid}, 32'd0);
    chk("cmd_ready after take", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Build the accumulator up to target with add=1 runs starting from a clear.
  task automatic preload(input int target);
    int cur;
    int n;
    do_cmd(1'b1, 0, 1'b1, 0, 16'd0, 1'b0, 1'b0, 0);
    cur = 0;
    while (cur < target) begin
      n = (target - cur > 255) ? 255 : target - cur;
      cur += n;
      do_cmd(1'b1, n, 1'b0, 0, cur[15:0], 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b1,   5, 1'b1, 0, 16'd5,   1'b0, 1'b0, 0};
    vecs[1] = '{1'b1,   3, 1'b0, 0, 16'd8,   1'b0, 1'b0, 2};
    vecs[2] = '{1'b0,   4, 1'b0, 0, 16'd8,   1'b0, 1'b0, 0};
    vecs[3] = '{1'b1,   0, 1'b1, 0, 16'd0,   1'b0, 1'b0, 1};
    vecs[4] = '{1'b1,  10, 1'b1, 4, 16'd3,   1'b0, 1'b1, 0};
    vecs[5] = '{1'b1,   2, 1'b1, 2, 16'd1,   1'b0, 1'b1, 0};
    vecs[6] = '{1'b1, 255, 1'b0, 0, 16'd256, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b1,   0, 1'b0, 0, 16'd256, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b1,   1, 1'b0, 1, 16'd256, 1'b0, 1'b1, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");
    chk("reset res_ovf", {31'd0, res_ovf}, 32'd0);
    chk("reset res_aborted", {31'd0, res_aborted}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_cmd(vecs[i].add, vecs[i].steps, vecs[i].clr, vecs[i].abort_at,
             vecs[i].data, vecs[i].ovf, vecs[i].ab, vecs[i].hold);
    end

    // Zero-step runs from 0x1234: no clear keeps the value, clear zeros it.
    preload(32'h1234);
    do_cmd(1'b1, 0, 1'b0, 0, 16'h1234, 1'b0, 1'b0, 0);
    do_cmd(1'b1, 0, 1'b1, 0, 16'h0000, 1'b0, 1'b0, 0);

    // Wrap through 0xFFFF: sticky overflow, then a clear run resets it.
    preload(32'hFFFE);
    do_cmd(1'b1, 3, 1'b0, 0, 16'h0001, 1'b1, 1'b0, 0);
    do_cmd(1'b1, 1, 1'b1, 0, 16'h0001, 1'b0, 1'b0, 0);

    // Reset in the middle of a run.
    cmd_valid = 1'b1; cmd_add = 1'b1; cmd_steps = 8'd10; cmd_clear = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy mid-run", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mid-run reset");

    // Reset while a result is held un-taken.
    cmd_valid = 1'b1; cmd_add = 1'b1; cmd_steps = 8'd2; cmd_clear = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("held result valid", {31'd0, res_valid}, 32'd1);
    chk("held result data", {16'd0, res_data}, 32'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("done reset");

    // Accumulator really cleared by reset: a no-clear run starts from 0.
    do_cmd(1'b1, 1, 1'b0, 0, 16'd1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_run_ctrl.md
# acc_run_ctrl

Run controller that owns and sequences the accumulator datapath. It accepts one command at a time; each command gives an addend and a step count. It then adds the addend to the accumulator once per cycle for that many cycles and presents the result through a valid/ready handshake. It sits between the top-level glue and the accumulator core, replacing the free-running accumulator with a commanded, observable one. The accumulator MSB stays exported for the existing single-pin output.

## Interface
Parameters:
- ACC_WIDTH, 16, accumulator width in bits
- ADD_WIDTH, 1, addend width in bits; must be ≤ ACC_WIDTH
- CNT_WIDTH, 8, step-count width; maximum run length is 2^CNT_WIDTH−1 adds

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_add  in  ADD_WIDTH  addend, zero-extended to ACC_WIDTH
- cmd_steps  in  CNT_WIDTH  number of adds to perform
- cmd_clear  in  1  zero the accumulator before this run
- abort  in  1  end the current run early
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- res_data  out  ACC_WIDTH  accumulator value
- res_ovf  out  1  sticky: at least one add in this run carried out of the MSB
- res_aborted  out  1  run was ended by abort
- busy  out  1  state is RUN
- acc_msb  out  1  res_data[ACC_WIDTH−1], live

## Operation
- Three states.
  - IDLE: cmd_ready=1.
  - RUN: busy=1.
  - DONE: res_valid=1.
- IDLE→RUN on cmd_valid&&cmd_ready when cmd_steps≠0. The acceptance edge does all of the following:
  - latches the addend;
  - loads the counter with cmd_steps;
  - clears res_ovf and res_aborted;
  - zeros the accumulator if cmd_clear=1.
- IDLE→DONE on acceptance with cmd_steps=0. The clear still applies; no add is performed.
- RUN, every edge:
  - acc ← acc + addend, modulo 2^ACC_WIDTH;
  - res_ovf |= carry-out;
  - counter decrements.
  - When the counter is 1 at that edge, go to DONE.
- abort=1 in RUN: go to DONE on that edge with no add performed that cycle; res_aborted=1. abort is ignored in IDLE and DONE.
- Abort and the final step in the same cycle: abort wins. The final add is not performed and res_aborted=1.
- DONE→IDLE on res_valid&&res_ready.
- The accumulator holds its value across runs unless cmd_clear is set. Wrap-around is silent apart from res_ovf.
- res_data, res_ovf and res_aborted are stable whenever res_valid=1.
- Reset, from any state including mid-RUN:
  - state=IDLE; acc, counter, addend, res_ovf and res_aborted all 0;
  - outputs: cmd_ready=1, res_valid=0, busy=0, acc_msb=0.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Accept at edge k with N≥1: adds occur at edges k+1…k+N. res_valid is high in the cycle after edge k+N, i.e. latency N+1 cycles from acceptance.
- N=0: res_valid is high in the cycle after the acceptance edge.
- Result taken at edge j: cmd_ready is high from edge j onward; the earliest next acceptance is edge j+1. There is no same-cycle result→command bypass.
- cmd_* inputs are sampled only on the acceptance edge. Changes during RUN are ignored.
- Back-to-back throughput: one command every N+2 cycles.

## Structure
- Shared package acc_pkg:
  - state enum (IDLE, RUN, DONE);
  - default width constants ACC_WIDTH, ADD_WIDTH, CNT_WIDTH.
- Sub-module acc_ripple_core holds the accumulator datapath:
  - accumulator register plus ripple-carry adder;
  - inputs en, clr, add_value;
  - outputs data, carry_out.
- The FSM, step counter and flags live in acc_run_ctrl.

## Test plan
- Reset, then accept {add=1, steps=5, clear=1} → res_valid high 6 cycles after acceptance; res_data=5, res_ovf=0, res_aborted=0.
- Second command {add=1, steps=3, clear=0} after taking the first result → res_data=8. The earliest cmd_ready is the edge the result was taken, not earlier.
- Preload via runs to 0xFFFE, then {add=1, steps=3} → res_data=0x0001, res_ovf=1. The following clear run reports res_ovf=0.
- {steps=0, clear=1} with acc=0x1234 → res_valid one cycle after acceptance, res_data=0x0000. {steps=0, clear=0} → value unchanged.
- {add=1, steps=10, clear=1}, abort asserted on the 4th RUN cycle → res_data=3, res_aborted=1. Abort coincident with the last step of a steps=2 run → res_data=1.
- rst asserted mid-RUN, and separately with res_valid held and res_ready=0 → next cycle: IDLE, cmd_ready=1, res_valid=0, res_data=0, acc_msb=0.
